// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin scheduler sharing one up-counter delay timer among NREQ requesters.
// Define TIMER_ARB_ABORT_EN to abandon a transaction when its requester drops io_req while counting.
module timer_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          io_req,
  input  logic [NREQ*WIDTH-1:0]    io_len,
  output logic [NREQ-1:0]          io_grant,
  output logic                     io_busy,
  output logic                     io_done,
  output logic [$clog2(NREQ)-1:0]  io_done_id,
  output logic [WIDTH-1:0]         io_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic [WIDTH-1:0] len_arr [NREQ];
  logic             found;
  logic [IDW-1:0]   pick;
  logic [IDW:0]     idx;
  logic [IDW-1:0]   winner_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_arr[gi] = io_len[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Walk offsets from far to near so the requester closest to ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (io_req[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  assign winner_inc = (winner_q == IDW'(NREQ - 1)) ? '0 : winner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    len_d    = len_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = COUNT;
          winner_d = pick;
          len_d    = len_arr[pick];
          count_d  = '0;
        end
      end
      COUNT: begin
`ifdef TIMER_ARB_ABORT_EN
        if (!io_req[winner_q]) begin
          state_d = IDLE;
          count_d = '0;
          ptr_d   = winner_inc;
        end else
`endif
        if (count_q == len_q) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = winner_inc;
        count_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      len_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      len_q    <= len_d;
      count_q  <= count_d;
    end
  end

  assign io_busy    = (state_q != IDLE);
  assign io_done    = (state_q == DONE);
  assign io_done_id = io_done ? winner_q : '0;
  assign io_count   = count_q;

  always_comb begin
    io_grant = '0;
    if (io_busy) io_grant[winner_q] = 1'b1;
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: vector table, hand-written corner sequences and a
// randomized run against a time-since-grant reference model (honours TIMER_ARB_ABORT_EN).
module tb_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  io_grant;
  logic        io_busy;
  logic        io_done;
  logic [1:0]  io_done_id;
  logic [3:0]  io_count;

  int tests;
  int fails;

  timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_req     (req),
    .io_len     (len),
    .io_grant   (io_grant),
    .io_busy    (io_busy),
    .io_done    (io_done),
    .io_done_id (io_done_id),
    .io_count   (io_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic [1:0]  id;
    logic [3:0]  count;
  } vec_t;

  vec_t vecs [10];

  // Reference model: owner (-1 when free), cycles elapsed since grant, sampled length, pointer.
  int m_owner;
  int m_t;
  int m_len;
  int m_ptr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic eb,
                       input logic ed, input logic [1:0] ei, input logic [3:0] ec,
                       input logic verbose);
    logic ok;
    tests++;
    ok = (io_grant === eg) && (io_busy === eb) && (io_done === ed) &&
         (io_count === ec) && (!ed || (io_done_id === ei));
    if (!ok) begin
      fails++;
      $display("FAIL %s: got grant=%b busy=%b done=%b id=%0d count=%0d, want grant=%b busy=%b done=%b id=%0d count=%0d",
               name, io_grant, io_busy, io_done, io_done_id, io_count, eg, eb, ed, ei, ec);
    end else if (verbose) begin
      $display("[TB] %s grant=%b busy=%b done=%b id=%0d count=%0d", name, io_grant, io_busy,
               io_done, io_done_id, io_count);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] r, input logic [15:0] l);
    logic found;
    int   i;
    if (rst) begin
      m_owner = -1; m_t = 0; m_len = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (!found && r[i]) begin
          found   = 1'b1;
          m_owner = i;
          m_len   = int'((l >> (i * WIDTH)) & 16'h000F);
          m_t     = 0;
        end
      end
    end else if (m_t == m_len + 1) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end
`ifdef TIMER_ARB_ABORT_EN
    else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end
`endif
    else begin
      m_t++;
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg;
    logic       eb;
    logic       ed;
    int         ec;
    eb = (m_owner >= 0);
    eg = eb ? 4'(1 << m_owner) : 4'b0000;
    ed = eb && (m_t == m_len + 1);
    ec = !eb ? 0 : ((m_t > m_len) ? m_len : m_t);
    check(name, eg, eb, ed, 2'(m_owner), 4'(ec), ed);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req   = '0;
    len   = '0;

    // Single request with L=3, then zero length on requester 2.
    vecs[0] = '{1'b1, 4'b0000, 16'h0003, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[1] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd0};
    vecs[2] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd1};
    vecs[3] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd2};
    vecs[4] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd3};
    vecs[5] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 1'b1, 1'b1, 2'd0, 4'd3};
    vecs[6] = '{1'b0, 4'b0000, 16'h0003, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[7] = '{1'b0, 4'b0100, 16'h0003, 4'b0100, 1'b1, 1'b0, 2'd0, 4'd0};
    vecs[8] = '{1'b0, 4'b0100, 16'h0003, 4'b0100, 1'b1, 1'b1, 2'd2, 4'd0};
    vecs[9] = '{1'b0, 4'b0000, 16'h0003, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0};

    for (int v = 0; v < 10; v++) begin
      reset = vecs[v].rst;
      req   = vecs[v].req;
      len   = vecs[v].len;
      tick();
      check($sformatf("vec%0d", v), vecs[v].grant, vecs[v].busy, vecs[v].done,
            vecs[v].id, vecs[v].count, 1'b1);
    end

    // Round-robin: all requesting with L=1 gives grants 0,1,2,3,0 with an IDLE gap.
    reset = 1'b1; req = '0; tick(); reset = 1'b0;
    req = 4'b1111; len = 16'h1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] w;
      w = 4'b0001 << (g % 4);
      tick(); check("rr_c0",   w, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
      tick(); check("rr_c1",   w, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0);
      tick(); check("rr_done", w, 1'b1, 1'b1, 2'(g % 4), 4'd1, 1'b1);
      tick(); check("rr_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    end
    req = '0;

    // Length is sampled at grant only.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0010; len = 16'h0050;
    tick(); check("len_c0", 4'b0010, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    tick(); check("len_c1", 4'b0010, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0);
    len = 16'h0020;
    for (int c = 2; c <= 5; c++) begin
      tick(); check("len_cnt", 4'b0010, 1'b1, 1'b0, 2'd0, 4'(c), 1'b0);
    end
    tick(); check("len_done", 4'b0010, 1'b1, 1'b1, 2'd1, 4'd5, 1'b1);
    req = '0;
    tick(); check("len_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);

    // Reset mid-count (ptr is 2 here) clears everything and restarts search at 0.
    req = 4'b0100; len = 16'h0700;
    tick(); check("rst_c0", 4'b0100, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    tick(); check("rst_c1", 4'b0100, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0);
    tick(); check("rst_c2", 4'b0100, 1'b1, 1'b0, 2'd0, 4'd2, 1'b0);
    reset = 1'b1;
    tick(); check("rst_clear", 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    reset = 1'b0; req = 4'b1001; len = 16'h0000;
    tick(); check("rst_ptr", 4'b0001, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
    req = '0; reset = 1'b1; tick(); reset = 1'b0;

    // Requester 3 drops its request at count=1 with L=6.
    req = 4'b1000; len = 16'h6000;
    tick(); check("ab_c0", 4'b1000, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    tick(); check("ab_c1", 4'b1000, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0);
    req = 4'b0000;
    tick();
`ifdef TIMER_ARB_ABORT_EN
    check("ab_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    req = 4'b1001; len = 16'h0000;
    tick(); check("ab_ptr", 4'b0001, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
    req = '0;
`else
    check("noab_c2", 4'b1000, 1'b1, 1'b0, 2'd0, 4'd2, 1'b0);
    for (int c = 3; c <= 6; c++) begin
      tick(); check("noab_cnt", 4'b1000, 1'b1, 1'b0, 2'd0, 4'(c), 1'b0);
    end
    tick(); check("noab_done", 4'b1000, 1'b1, 1'b1, 2'd3, 4'd6, 1'b1);
    tick(); check("noab_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
`endif

    // Randomized run against the reference model.
    reset = 1'b1; req = '0; len = '0;
    tick();
    model_edge(reset, req, len);
    check_model("rnd_reset");
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      req   = 4'($urandom_range(0, 15));
      len   = 16'($urandom);
      tick();
      model_edge(reset, req, len);
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin scheduler that shares a single 4-bit up-counter timer between several requesters. Each requester asks for a delay of N ticks. The arbiter grants one requester, loads and runs the counter, and pulses completion back to the winner. It sits in front of the counter datapath, which is otherwise free-running, and turns it into a shared, sequenced delay resource.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, counter and length width in bits

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- io_req  input  NREQ  per-requester request, level
- io_len  input  NREQ*WIDTH  per-requester delay length; slice i is bits [i*WIDTH +: WIDTH]
- io_grant  output  NREQ  one-hot grant, all-zero when idle
- io_busy  output  1  high whenever the timer is owned
- io_done  output  1  one-cycle completion pulse
- io_done_id  output  log2(NREQ)  index of the completing requester, valid with io_done
- io_count  output  WIDTH  current counter value

## Operation
- States:
  - IDLE: no owner, io_count=0.
  - COUNT: owner running.
  - DONE: completion cycle.
- IDLE: if any io_req is high, select the winner by round-robin starting at pointer ptr, searching ptr, ptr+1, … modulo NREQ.
  - Latch the winner index and io_len slice into L.
  - Clear the counter to 0.
  - Go to COUNT.
- COUNT: each edge, if count != L, count <= count+1. If count == L, go to DONE.
- DONE: assert io_done=1 and io_done_id=winner for one cycle. Next edge: go to IDLE and set ptr <= (winner+1) mod NREQ.
- io_grant[winner] and io_busy are high in COUNT and DONE, and low in IDLE.
- The length is sampled only at grant. Later changes to io_len are ignored.
- Arithmetic is unsigned WIDTH bits. Count never exceeds L, so it never wraps.
- L=0: COUNT lasts one cycle with count=0, then DONE.
- A requester must hold io_req until it sees io_done for its index. Deassertion before that is handled per Configuration.
- Requests arriving while busy wait. There is no queueing beyond the level io_req lines.
- Reset values:
  - state=IDLE, ptr=0, counter=0
  - io_grant=0, io_busy=0, io_done=0, io_done_id=0, io_count=0
- Reset asserted in any state returns all state to these values at the next edge. No done pulse is emitted for the interrupted transaction.

## Timing
- Request sampled at edge E0 in IDLE gives a grant visible from E0+ (after the edge). io_count then runs 0,1,…,L on successive cycles (L+1 cycles in COUNT).
- io_done is high for exactly one cycle, L+1 cycles after grant. Grant spans L+2 cycles in total.
- At least one IDLE cycle separates consecutive grants. The earliest next grant is 2 edges after the edge that entered DONE.
- All outputs are registered or decoded from registered state only. There are no combinational paths from io_req or io_len to outputs.

## Configuration
- TIMER_ARB_ABORT_EN defined:
  - In COUNT, if io_req[winner] is low at an edge, go directly to IDLE at that edge.
  - No io_done pulse is emitted; counter clears to 0; ptr <= (winner+1) mod NREQ.
  - An abort seen in DONE is ignored.
- TIMER_ARB_ABORT_EN undefined: io_req is ignored after grant, and the transaction always runs to DONE.

## Test plan
- Single request: reset, then io_req=0001 with len0=3 → grant=0001 for 5 cycles; io_count 0,1,2,3 then held in DONE; io_done=1 with io_done_id=0 exactly once; grant=0 the following cycle.
- Zero length: io_req=0100 with len2=0 → one COUNT cycle with io_count=0, then io_done with id=2; total grant of 2 cycles.
- Round-robin fairness: io_req=1111 held with all lengths=1 → grants in order 0,1,2,3,0; done ids match; one IDLE cycle between each grant.
- Length sampled at grant: len1=5 at grant, then changed to 2 mid-count → io_count still reaches 5 before io_done.
- Reset mid-operation: assert reset while io_count=2 with L=7 → next cycle all outputs 0, no io_done; next grant starts search at index 0.
- Abort, TIMER_ARB_ABORT_EN defined: drop io_req[3] at io_count=1, L=6 → IDLE next cycle, no io_done, ptr=0. With the macro undefined, the same stimulus gives io_done for id 3 after io_count reaches 6.
